mem_arbiter: RTL and testbench

//  Upstream request arbiter for memory_unit. Two clients (evaluator c0, traversal c1)

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Command/response bundle between the two clients, mem_arbiter and memory_unit.
// slave = arbiter side; master = environment (clients plus memory_unit).
interface mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
);
    // Client handshake: raise cN_req with func/addr/wdata and hold all of them stable
    // until cN_done is seen high for one cycle; req is dropped after that cycle.
    logic              c0_req,   c1_req;
    logic [1:0]        c0_func,  c1_func;
    logic [ADDR_W-1:0] c0_addr1, c1_addr1, c0_addr2, c1_addr2;
    logic [DATA_W-1:0] c0_wdata, c1_wdata;
    logic              c0_done,  c1_done, c0_err, c1_err;
    logic [DATA_W-1:0] rsp_rdata1, rsp_rdata2;
    logic [ADDR_W-1:0] rsp_free_addr;
    logic              gc_done;
    logic [ADDR_W-1:0] gc_root;
    logic [1:0]        mem_func;
    logic              mem_execute, mem_gc_ready, mem_is_ready, mem_gc;
    logic [ADDR_W-1:0] mem_address1, mem_address2, mem_free_addr;
    logic [DATA_W-1:0] mem_write_data, mem_read_data1, mem_read_data2;
    logic [2:0]        dbg_state;

    modport slave (
        input  c0_req, c0_func, c0_addr1, c0_addr2, c0_wdata,
        input  c1_req, c1_func, c1_addr1, c1_addr2, c1_wdata,
        input  mem_is_ready, mem_read_data1, mem_read_data2, mem_free_addr, mem_gc,
        output c0_done, c0_err, c1_done, c1_err, rsp_rdata1, rsp_rdata2, rsp_free_addr,
        output gc_done, gc_root, mem_func, mem_execute, mem_address1, mem_address2,
        output mem_write_data, mem_gc_ready, dbg_state
    );

    modport master (
        output c0_req, c0_func, c0_addr1, c0_addr2, c0_wdata,
        output c1_req, c1_func, c1_addr1, c1_addr2, c1_wdata,
        output mem_is_ready, mem_read_data1, mem_read_data2, mem_free_addr, mem_gc,
        input  c0_done, c0_err, c1_done, c1_err, rsp_rdata1, rsp_rdata2, rsp_free_addr,
        input  gc_done, gc_root, mem_func, mem_execute, mem_address1, mem_address2,
        input  mem_write_data, mem_gc_ready, dbg_state
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for two clients sharing memory_unit, owning the GC handshake.
// Define MEM_ARB_GC_RETRY_EN to reissue a GC-interrupted GET_FREE instead of returning err.
module mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] FUNC_GET_FREE = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_SETTLE, S_WAIT_DONE, S_GC_RUN, S_GC_END
    } state_t;

    state_t            state, state_nx;
    logic              last_grant, owner, interrupted, retry_pend;
    logic              req0, req1;
    logic              grant_en, grant_id, complete, gc_finish, err_done;
    logic [1:0]        func_q;
    logic [ADDR_W-1:0] addr1_q, addr2_q, free_q, root_q;
    logic [DATA_W-1:0] wdata_q, rdata1_q, rdata2_q;
    logic              done0_q, done1_q, err0_q, err1_q, gc_done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // The client whose done is showing still has req up this cycle; it must not win again.
    assign req0 = bus.c0_req & ~done0_q;
    assign req1 = bus.c1_req & ~done1_q;

    always_comb begin
        state_nx  = state;
        grant_en  = 1'b0;
        grant_id  = 1'b0;
        complete  = 1'b0;
        gc_finish = 1'b0;
        err_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.mem_gc) begin
                    state_nx = S_GC_RUN;
                end else if (bus.mem_is_ready) begin
                    if (retry_pend) begin
                        state_nx = S_ISSUE;
                    end else if (req0 | req1) begin
                        grant_en = 1'b1;
                        grant_id = (req0 & req1) ? ~last_grant : req1;
                        state_nx = S_ISSUE;
                    end
                end
            end
            S_ISSUE:  state_nx = S_SETTLE;
            // memory_unit needs this cycle to drop is_ready after execute.
            S_SETTLE: state_nx = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (bus.mem_gc) begin
                    state_nx = S_GC_RUN;
                end else if (bus.mem_is_ready) begin
                    complete = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_GC_RUN: begin
                if (!bus.mem_gc) begin
                    gc_finish = 1'b1;
                    state_nx  = S_GC_END;
                end
            end
            S_GC_END: begin
                state_nx = S_IDLE;
`ifndef MEM_ARB_GC_RETRY_EN
                err_done = interrupted && (func_q == FUNC_GET_FREE);
`endif
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            interrupted <= 1'b0;
            retry_pend  <= 1'b0;
            func_q      <= '0;
            addr1_q     <= '0;
            addr2_q     <= '0;
            wdata_q     <= '0;
            rdata1_q    <= '0;
            rdata2_q    <= '0;
            free_q      <= '0;
            root_q      <= '0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            gc_done_q   <= 1'b0;
        end else begin
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            gc_done_q <= 1'b0;
            if (grant_en) begin
                owner   <= grant_id;
                func_q  <= grant_id ? bus.c1_func  : bus.c0_func;
                addr1_q <= grant_id ? bus.c1_addr1 : bus.c0_addr1;
                addr2_q <= grant_id ? bus.c1_addr2 : bus.c0_addr2;
                wdata_q <= grant_id ? bus.c1_wdata : bus.c0_wdata;
            end
            if (complete) begin
                rdata1_q   <= bus.mem_read_data1;
                rdata2_q   <= bus.mem_read_data2;
                free_q     <= bus.mem_free_addr;
                done0_q    <= ~owner;
                done1_q    <= owner;
                last_grant <= owner;
            end
            if (err_done) begin
                done0_q    <= ~owner;
                done1_q    <= owner;
                err0_q     <= ~owner;
                err1_q     <= owner;
                last_grant <= owner;
            end
            if (state == S_WAIT_DONE && bus.mem_gc) interrupted <= 1'b1;
            else if (state == S_GC_END)            interrupted <= 1'b0;
            if (gc_finish) begin
                root_q    <= bus.mem_read_data1[ADDR_W-1:0];
                gc_done_q <= 1'b1;
            end
`ifdef MEM_ARB_GC_RETRY_EN
            // Saved command regs are untouched, so IDLE simply re-enters ISSUE for the same owner.
            if (state == S_GC_END && interrupted && func_q == FUNC_GET_FREE) retry_pend <= 1'b1;
            else if (state == S_ISSUE)                                       retry_pend <= 1'b0;
`else
            retry_pend <= 1'b0;
`endif
        end
    end

    assign bus.mem_execute    = (state == S_ISSUE);
    assign bus.mem_gc_ready   = (state == S_GC_RUN);
    assign bus.mem_func       = func_q;
    assign bus.mem_address1   = addr1_q;
    assign bus.mem_address2   = addr2_q;
    assign bus.mem_write_data = wdata_q;
    assign bus.c0_done        = done0_q;
    assign bus.c1_done        = done1_q;
    assign bus.c0_err         = err0_q;
    assign bus.c1_err         = err1_q;
    assign bus.rsp_rdata1     = rdata1_q;
    assign bus.rsp_rdata2     = rdata2_q;
    assign bus.rsp_free_addr  = free_q;
    assign bus.gc_done        = gc_done_q;
    assign bus.gc_root        = root_q;
    assign bus.dbg_state      = state;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural memory_unit stand-in.
// Honours MEM_ARB_GC_RETRY_EN the same way the design does.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 64;
    localparam logic [1:0] F_GET = 2'd0, F_SET = 2'd1, F_FREE = 2'd2;
    localparam int MEM_LIMIT = 512;
    localparam int GC_BASE   = 40;
    localparam int INIT_FREE = 10;

    typedef struct packed {
        logic              err;
        logic              chk_rd;
        logic              chk_free;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [ADDR_W-1:0] free;
    } exp_t;

    logic clk, rst;
    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q0[$];
    exp_t exp_q1[$];
    logic [ADDR_W-1:0] gc_exp_q[$];
    int   done_log[$];
    bit   log_en = 0;
    int   gc_seen = 0;
    logic [DATA_W-1:0] ref_mem [0:1023];
    logic [DATA_W-1:0] model_mem [0:1023];
    int   ref_free = INIT_FREE;
    int   model_free = INIT_FREE;
    int   lat_fixed = 0;
    bit   force_gc = 0;
    bit   model_busy = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- client driver tasks ----------------
    task automatic push_exp(input int cid, input exp_t e);
        if (cid == 0) exp_q0.push_back(e);
        else          exp_q1.push_back(e);
    endtask

    task automatic do_txn(input int cid, input logic [1:0] f, input logic [ADDR_W-1:0] a1,
                          input logic [ADDR_W-1:0] a2, input logic [DATA_W-1:0] wd);
        int n = 0;
        bit seen = 0;
        if (cid == 0) begin
            bus.c0_func = f; bus.c0_addr1 = a1; bus.c0_addr2 = a2; bus.c0_wdata = wd; bus.c0_req = 1'b1;
        end else begin
            bus.c1_func = f; bus.c1_addr1 = a1; bus.c1_addr2 = a2; bus.c1_wdata = wd; bus.c1_req = 1'b1;
        end
        while (!seen && n < 600) begin
            @(negedge clk);
            n++;
            seen = (cid == 0) ? bus.c0_done : bus.c1_done;
        end
        check($sformatf("c%0d_done_in_time", cid), 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        if (cid == 0) bus.c0_req = 1'b0;
        else          bus.c1_req = 1'b0;
    endtask

    task automatic c_set(input int cid, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_t e = '0;
        ref_mem[a] = d;
        push_exp(cid, e);
        do_txn(cid, F_SET, a, '0, d);
    endtask

    task automatic c_get(input int cid, input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
        exp_t e = '0;
        e.chk_rd = 1'b1;
        e.rd1    = ref_mem[a1];
        e.rd2    = ref_mem[a2];
        push_exp(cid, e);
        do_txn(cid, F_GET, a1, a2, '0);
    endtask

    // Allocation rule: base = current free pointer; an allocation that would pass
    // MEM_LIMIT triggers GC, which compacts the heap down to GC_BASE first.
    task automatic c1_free(input int n);
        bit   finished = 0;
        exp_t e;
        while (!finished) begin
            e = '0;
            if (ref_free + n > MEM_LIMIT) begin
                ref_free = GC_BASE;
`ifdef MEM_ARB_GC_RETRY_EN
                e.chk_free = 1'b1;
                e.free     = ADDR_W'(ref_free);
                ref_free   = ref_free + n;
                finished   = 1;
`else
                e.err = 1'b1;
`endif
            end else begin
                e.chk_free = 1'b1;
                e.free     = ADDR_W'(ref_free);
                ref_free   = ref_free + n;
                finished   = 1;
            end
            push_exp(1, e);
            do_txn(1, F_FREE, '0, '0, DATA_W'(n));
        end
    endtask

    // ---------------- memory_unit stand-in ----------------
    task automatic do_gc();
        logic [ADDR_W-1:0] root;
        int n = 0;
        bus.mem_is_ready = 1'b0;
        bus.mem_gc       = 1'b1;
        root = ADDR_W'($urandom_range(0, 1023));
        gc_exp_q.push_back(root);
        while (bus.mem_gc_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("gc_ready_rise", 64'(bus.mem_gc_ready), 64'd1);
        repeat (3) begin
            @(negedge clk);
            check("gc_ready_hold", 64'(bus.mem_gc_ready), 64'd1);
        end
        bus.mem_read_data1 = DATA_W'(root);
        bus.mem_gc         = 1'b0;
        model_free         = GC_BASE;
        bus.mem_is_ready   = 1'b1;
        @(negedge clk);
        check("gc_ready_fall", 64'(bus.mem_gc_ready), 64'd0);
    endtask

    initial begin
        logic [1:0]        f;
        logic [ADDR_W-1:0] a1, a2;
        logic [DATA_W-1:0] wd;
        int lat;
        forever begin
            @(negedge clk);
            if (bus.mem_execute === 1'b1) begin
                model_busy = 1;
                bus.mem_is_ready = 1'b0;
                f = bus.mem_func; a1 = bus.mem_address1; a2 = bus.mem_address2; wd = bus.mem_write_data;
                lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
                for (int i = 0; i < lat; i++) begin
                    @(negedge clk);
                    if (i == 0) check("exec_one_cycle", 64'(bus.mem_execute), 64'd0);
                end
                if (lat_fixed == 0)
                    check("cmd_held", {bus.mem_func, bus.mem_address1, bus.mem_address2}, {f, a1, a2});
                if (f == F_FREE && model_free + int'(wd) > MEM_LIMIT) begin
                    do_gc();
                end else begin
                    case (f)
                        F_GET: begin
                            bus.mem_read_data1 = model_mem[a1];
                            bus.mem_read_data2 = model_mem[a2];
                        end
                        F_SET: model_mem[a1] = wd;
                        F_FREE: begin
                            bus.mem_free_addr = ADDR_W'(model_free);
                            model_free = model_free + int'(wd);
                        end
                        default: ;
                    endcase
                    bus.mem_is_ready = 1'b1;
                end
                model_busy = 0;
            end else if (force_gc) begin
                force_gc = 0;
                do_gc();
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    task automatic check_rsp(input int cid);
        exp_t e;
        logic err;
        if ((cid == 0 && exp_q0.size() == 0) || (cid == 1 && exp_q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL c%0d_unexpected_done: got done with no outstanding request, required none", cid);
            return;
        end
        e   = (cid == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        err = (cid == 0) ? bus.c0_err : bus.c1_err;
        check($sformatf("c%0d_err", cid), 64'(err), 64'(e.err));
        if (e.chk_rd) begin
            check($sformatf("c%0d_rdata1", cid), bus.rsp_rdata1, e.rd1);
            check($sformatf("c%0d_rdata2", cid), bus.rsp_rdata2, e.rd2);
        end
        if (e.chk_free) check($sformatf("c%0d_free_addr", cid), 64'(bus.rsp_free_addr), 64'(e.free));
        if (log_en) done_log.push_back(cid);
    endtask

    initial begin
        logic [ADDR_W-1:0] r;
        forever begin
            @(negedge clk);
            if (bus.c0_done === 1'b1 && bus.c1_done === 1'b1) check("done_exclusive", 64'd1, 64'd0);
            if (bus.c0_done === 1'b1) check_rsp(0);
            if (bus.c1_done === 1'b1) check_rsp(1);
            if (bus.gc_done === 1'b1) begin
                gc_seen++;
                if (gc_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL gc_unexpected_done: got gc_done with no GC, required none");
                end else begin
                    r = gc_exp_q.pop_front();
                    check("gc_root", 64'(bus.gc_root), 64'(r));
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        bit ex;
        logic [ADDR_W-1:0] a, a2;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = '0;
            model_mem[i] = '0;
        end
        bus.c0_req = 0; bus.c0_func = '0; bus.c0_addr1 = '0; bus.c0_addr2 = '0; bus.c0_wdata = '0;
        bus.c1_req = 0; bus.c1_func = '0; bus.c1_addr1 = '0; bus.c1_addr2 = '0; bus.c1_wdata = '0;
        bus.mem_is_ready = 0; bus.mem_gc = 0; bus.mem_read_data1 = '0; bus.mem_read_data2 = '0;
        bus.mem_free_addr = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", 64'({bus.c0_done, bus.c1_done, bus.c0_err, bus.c1_err, bus.gc_done,
                               bus.mem_execute, bus.mem_gc_ready}), 64'd0);
        check("rst_rdata1", bus.rsp_rdata1, 64'd0);
        check("rst_free_root", 64'({bus.rsp_free_addr, bus.gc_root}), 64'd0);
        check("rst_mem_cmd", 64'({bus.mem_func, bus.mem_address1, bus.mem_address2}), 64'd0);
        check("rst_wdata", bus.mem_write_data, 64'd0);
        rst = 1'b1;

        // memory_unit still initialising: a pending request must not be issued
        fork
            c_set(0, 10'd5, 64'hABCD);
            begin
                ex = 0;
                repeat (20) begin
                    @(negedge clk);
                    ex |= bus.mem_execute;
                end
                check("no_exec_during_init", 64'(ex), 64'd0);
                bus.mem_is_ready = 1'b1;
            end
        join
        c_get(0, 10'd5, 10'd0);
        c1_free(4);
        c1_free(2);

        // simultaneous requests alternate starting from c0
        log_en = 1;
        fork
            begin c_set(0, 10'd7, 64'h77); c_get(0, 10'd7, 10'd5); end
            begin c_set(1, 10'd300, 64'h1234_5678); c_get(1, 10'd300, 10'd301); end
        join
        log_en = 0;
        check("arb_count", 64'(done_log.size()), 64'd4);
        for (int i = 0; i < done_log.size() && i < 4; i++)
            check($sformatf("arb_order_%0d", i), 64'(done_log[i]), 64'(i % 2));

        // async reset while waiting for memory_unit
        lat_fixed = 30;
        bus.c0_func = F_GET; bus.c0_addr1 = 10'd5; bus.c0_addr2 = 10'd0; bus.c0_req = 1'b1;
        n = 0;
        while (bus.mem_execute !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_test_issue", 64'(bus.mem_execute), 64'd1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_ctrl", 64'({bus.c0_done, bus.c1_done, bus.mem_execute, bus.mem_gc_ready,
                                     bus.gc_done}), 64'd0);
        check("async_rst_rdata1", bus.rsp_rdata1, 64'd0);
        check("async_rst_state", 64'(bus.dbg_state), 64'd0);
        check("async_rst_addr1", 64'(bus.mem_address1), 64'd0);
        bus.c0_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (model_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        lat_fixed = 0;
        c_get(0, 10'd5, 10'd7);

        // GET_FREE that overflows the heap forces a GC
        c1_free(400);
        c1_free(200);
        check("gc_count_after_free", 64'(gc_seen), 64'd1);

        // GC with nothing outstanding
        repeat (3) @(negedge clk);
        ref_free = GC_BASE;
        force_gc = 1;
        n = 0;
        while (gc_seen < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_gc_done", 64'(gc_seen), 64'd2);
        c1_free(8);

        // random traffic from both clients in disjoint regions
        fork
            for (int i = 0; i < 30; i++) begin
                a  = ADDR_W'($urandom_range(0, 127));
                a2 = ADDR_W'($urandom_range(0, 127));
                if ($urandom_range(0, 1) == 0) c_set(0, a, {$urandom, $urandom});
                else                           c_get(0, a, a2);
            end
            for (int i = 0; i < 30; i++) begin
                a  = ADDR_W'(256 + $urandom_range(0, 127));
                a2 = ADDR_W'(256 + $urandom_range(0, 127));
                case ($urandom_range(0, 2))
                    0:       c_set(1, a, {$urandom, $urandom});
                    1:       c_get(1, a, a2);
                    default: c1_free(int'($urandom_range(1, 120)));
                endcase
            end
        join

        repeat (10) @(negedge clk);
        check("exp_q0_drained", 64'(exp_q0.size()), 64'd0);
        check("exp_q1_drained", 64'(exp_q1.size()), 64'd0);
        check("gc_q_drained", 64'(gc_exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
